// File: rtl/data_mux_seq.sv
// Registered N-way data multiplexer, addressed or round-robin scan, one-deep output register.
// Latency: capture in cycle N is visible as out_valid/out_data/out_chan in cycle N+1.
// Backpressure: while out_valid && !out_ready, captures are blocked and the scan pointer holds.
module data_mux_seq #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          addr,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      scan_wrap,
  output logic                      sel_err
);

  // One extra bit so CHANNELS itself is representable when it is a power of two.
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             slot_free;
  logic             capture;
  logic             addr_ok;
  logic             load;
  logic [SEL_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_dat;

  assign slot_free = !valid_q || out_ready;
  assign capture   = en && slot_free;
  assign addr_ok   = {1'b0, addr} < CH_LIMIT;
  assign load      = capture && (mode || addr_ok);
  assign sel_idx   = mode ? ptr_q : addr;

  // Channel selection as a compare-and-pick mux so indices past CHANNELS-1 select nothing.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_idx == SEL_W'(k)) begin
        sel_dat = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for output register, scan pointer and status pulses.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (load) begin
      valid_d = 1'b1;
      data_d  = sel_dat;
      chan_d  = sel_idx;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // Addressed mode parks the pointer at 0 so the next scan starts from channel 0.
    if (!mode) begin
      ptr_d = '0;
    end else if (capture) begin
      if (ptr_q == LAST_CH) begin
        ptr_d  = '0;
        wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end

    if (capture && !mode && !addr_ok) begin
      err_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = valid_q ? data_q : '0;
  assign out_chan  = chan_q;
  assign scan_wrap = wrap_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_data_mux_seq.sv
// Directed bench for data_mux_seq: three instances (16, 5 and 10 channels) share control inputs.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Expected values are hand-computed constants; channel k always carries 0x10+k.
module tb_data_mux_seq;

  logic clk;
  logic rst;
  logic en;
  logic mode;
  logic out_ready;

  logic [3:0]   addr16;
  logic [127:0] din16;
  logic         vld16, wrap16, err16;
  logic [7:0]   dat16;
  logic [3:0]   chan16;

  logic [2:0]   addr5;
  logic [39:0]  din5;
  logic         vld5, wrap5, err5;
  logic [7:0]   dat5;
  logic [2:0]   chan5;

  logic [3:0]   addr10;
  logic [79:0]  din10;
  logic         vld10, wrap10, err10;
  logic [7:0]   dat10;
  logic [3:0]   chan10;

  int n_cmp = 0;
  int n_bad = 0;

  data_mux_seq #(.WIDTH(8), .CHANNELS(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr16), .data_in(din16),
    .out_ready(out_ready), .out_valid(vld16), .out_data(dat16), .out_chan(chan16),
    .scan_wrap(wrap16), .sel_err(err16)
  );

  data_mux_seq #(.WIDTH(8), .CHANNELS(5)) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr5), .data_in(din5),
    .out_ready(out_ready), .out_valid(vld5), .out_data(dat5), .out_chan(chan5),
    .scan_wrap(wrap5), .sel_err(err5)
  );

  data_mux_seq #(.WIDTH(8), .CHANNELS(10)) u_dut10 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr10), .data_in(din10),
    .out_ready(out_ready), .out_valid(vld10), .out_data(dat10), .out_chan(chan10),
    .scan_wrap(wrap10), .sel_err(err10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int scan_exp [7];
    scan_exp = '{0, 1, 2, 3, 4, 0, 1};

    rst = 1'b1; en = 1'b0; mode = 1'b0; out_ready = 1'b1;
    addr16 = '0; addr5 = '0; addr10 = '0;
    for (int k = 0; k < 16; k++) din16[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 5; k++)  din5[k*8 +: 8]  = 8'(8'h10 + k);
    for (int k = 0; k < 10; k++) din10[k*8 +: 8] = 8'(8'h10 + k);

    // Reset state
    #3;
    chk("rst_valid", 32'(vld16), 32'h0);
    chk("rst_data",  32'(dat16), 32'h0);
    chk("rst_chan",  32'(chan16), 32'h0);
    chk("rst_wrap",  32'(wrap16), 32'h0);
    chk("rst_err",   32'(err16), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Addressed capture of channel 0xB, then consumed
    mode = 1'b0; addr16 = 4'hB; en = 1'b1; out_ready = 1'b1;
    tick();
    chk("addr_valid", 32'(vld16), 32'h1);
    chk("addr_data",  32'(dat16), 32'h1B);
    chk("addr_chan",  32'(chan16), 32'hB);
    en = 1'b0;
    tick();
    chk("addr_drain_valid", 32'(vld16), 32'h0);
    chk("addr_drain_data",  32'(dat16), 32'h0);

    // Scan on 5 channels: 0,1,2,3,4,0,1 with wrap pulse alongside channel 4
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("scan5_chan%0d", i), 32'(chan5), 32'(scan_exp[i]));
      chk($sformatf("scan5_data%0d", i), 32'(dat5), 32'(8'h10 + scan_exp[i]));
      chk($sformatf("scan5_wrap%0d", i), 32'(wrap5), (i == 4) ? 32'h1 : 32'h0);
    end
    mode = 1'b0; en = 1'b0;
    tick();
    chk("scan5_drain_valid", 32'(vld5), 32'h0);

    // Back-pressure on 16 channels: capture 0,1,2 then stall three cycles
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("bp_pre_chan", 32'(chan16), 32'h2);
    out_ready = 1'b0;
    din16[2*8 +: 8] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", i), 32'(vld16), 32'h1);
      chk($sformatf("bp_hold_chan%0d", i), 32'(chan16), 32'h2);
      chk($sformatf("bp_hold_data%0d", i), 32'(dat16), 32'h12);
    end
    din16[2*8 +: 8] = 8'h12;
    out_ready = 1'b1;
    tick();
    chk("bp_resume_chan", 32'(chan16), 32'h3);
    chk("bp_resume_data", 32'(dat16), 32'h13);
    mode = 1'b0; en = 1'b0;
    tick();

    // Bad address on 10 channels, then a valid top-channel address
    mode = 1'b0; en = 1'b1; out_ready = 1'b1; addr10 = 4'd12;
    tick();
    chk("bad_err",   32'(err10), 32'h1);
    chk("bad_valid", 32'(vld10), 32'h0);
    chk("bad_data",  32'(dat10), 32'h0);
    addr10 = 4'd9;
    tick();
    chk("good_err",   32'(err10), 32'h0);
    chk("good_valid", 32'(vld10), 32'h1);
    chk("good_data",  32'(dat10), 32'h19);
    chk("good_chan",  32'(chan10), 32'h9);
    en = 1'b0;
    tick();

    // Async reset mid-scan: ptr at 3 with channel 2 pending
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("ar_pre_chan",  32'(chan16), 32'h2);
    chk("ar_pre_valid", 32'(vld16), 32'h1);
    en = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(vld16), 32'h0);
    chk("ar_data",  32'(dat16), 32'h0);
    chk("ar_chan",  32'(chan16), 32'h0);
    #2 rst = 1'b0;
    en = 1'b1; out_ready = 1'b1;
    tick();
    chk("ar_first_chan", 32'(chan16), 32'h0);
    chk("ar_first_data", 32'(dat16), 32'h10);

    // Mode switch: scan on to ptr 4, one addressed idle cycle, scan restarts at 0
    tick(); tick(); tick();
    chk("ms_pre_chan", 32'(chan16), 32'h3);
    mode = 1'b0; en = 1'b0;
    tick();
    chk("ms_idle_valid", 32'(vld16), 32'h0);
    mode = 1'b1; en = 1'b1;
    tick();
    chk("ms_restart_chan", 32'(chan16), 32'h0);
    chk("ms_restart_data", 32'(dat16), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
